// File: rtl/ahfp_pkg.sv
// Shared floating-point helpers for the ahfp_* arithmetic blocks: operand
// classification plus format constants derived from the field widths.
package ahfp_pkg;

  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_t;

  function automatic int exp_max(input int ew);
    return (1 << ew) - 1;
  endfunction

  function automatic int bias(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction

  // Canonical quiet NaN, returned wide; callers slice to their own width.
  function automatic logic [127:0] qnan(input int ew, input int mw);
    logic [127:0] q;
    q = '0;
    for (int i = 0; i < ew; i++) q[mw + i] = 1'b1;
    q[mw - 1] = 1'b1;
    return q;
  endfunction

  // Bit positions of the fields in a {sign, exp, frac} word.
  function automatic int sign_pos(input int ew, input int mw);
    return ew + mw;
  endfunction

  function automatic int exp_lsb(input int mw);
    return mw;
  endfunction

  // Denormals are classed as ZERO: these blocks flush them on input.
  function automatic fp_class_t fp_classify(input logic exp_zero, input logic exp_ones,
                                            input logic frac_zero);
    if (exp_zero) return ZERO;
    if (exp_ones) return frac_zero ? INF : NAN;
    return NORM;
  endfunction

endpackage

// File: rtl/ahfp_lzc.sv
// Priority leading-zero counter; an all-zero input reports WIDTH.
module ahfp_lzc #(
  parameter int WIDTH = 27
) (
  input  logic [WIDTH-1:0]               vec,
  output logic [$clog2(WIDTH+1)-1:0]     cnt
);
  localparam int CW = $clog2(WIDTH + 1);

  // Scan upward so the highest set bit is the one that sticks.
  always_comb begin
    cnt = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++)
      if (vec[i]) cnt = CW'(WIDTH - 1 - i);
  end

endmodule

// File: rtl/ahfp_addsub_pipe.sv
// Four-stage floating-point add/subtract, round-to-nearest-even, flush-to-zero,
// with clock-enable stalls for use as a multi-cycle custom instruction.
module ahfp_addsub_pipe import ahfp_pkg::*; #(
  parameter int EXP_W   = 8,
  parameter int MAN_W   = 23,
  parameter int LATENCY = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clk_en,
  input  logic                     start,
  input  logic                     n,
  input  logic [EXP_W+MAN_W:0]     dataa,
  input  logic [EXP_W+MAN_W:0]     datab,
  output logic [EXP_W+MAN_W:0]     result,
  output logic                     done
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int SW  = MAN_W + 4;
  localparam int EW2 = EXP_W + 2;
  localparam int MW2 = MAN_W + 2;
  localparam int LZW = $clog2(SW + 1);

  localparam logic [127:0]            QNAN_WIDE = qnan(EXP_W, MAN_W);
  localparam logic [W-1:0]            QNAN      = QNAN_WIDE[W-1:0];
  localparam logic [W-1:0]            INF_MAG   = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  localparam logic [EXP_W-1:0]        SH_MAX    = EXP_W'(MAN_W + 3);
  localparam logic signed [EW2-1:0]   EXP_MAX_S = EW2'(exp_max(EXP_W));

  if (LATENCY != 4) begin : g_latency_check
    $error("ahfp_addsub_pipe: only LATENCY=4 is supported");
  end

  typedef struct packed {
    logic             spec;
    logic [W-1:0]     spec_val;
    logic             sign;
    logic             eff_sub;
    logic [EXP_W-1:0] exp_l;
    logic [EXP_W-1:0] exp_s;
    logic [MAN_W:0]   man_l;
    logic [MAN_W:0]   man_s;
  } s1_t;

  typedef struct packed {
    logic             spec;
    logic [W-1:0]     spec_val;
    logic             sign;
    logic             eff_sub;
    logic [EXP_W-1:0] exp_l;
    logic [SW-1:0]    sig_l;
    logic [SW-1:0]    sig_s;
  } s2_t;

  typedef struct packed {
    logic                  spec;
    logic [W-1:0]          spec_val;
    logic                  sign;
    logic                  zero;
    logic                  zero_sign;
    logic signed [EW2-1:0] exp;
    logic [SW-1:0]         norm;
  } s3_t;

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  s3_t s3_d, s3_q;
  logic [W-1:0]         s4_d;
  logic [LATENCY-1:0]   vld_pipe;

  // S1: unpack, classify, apply the mode to B's sign, order by magnitude.
  logic                     sa, sb, a_big;
  logic [EXP_W-1:0]         ea, eb;
  logic [MAN_W-1:0]         fa, fb;
  logic [EXP_W+MAN_W-1:0]   ka, kb;
  logic [MAN_W:0]           ma, mb;
  fp_class_t                ca, cb;

  always_comb begin
    sa = dataa[W-1];
    ea = dataa[W-2:MAN_W];
    fa = dataa[MAN_W-1:0];
    sb = datab[W-1] ^ n;
    eb = datab[W-2:MAN_W];
    fb = datab[MAN_W-1:0];
    ca = fp_classify(ea == '0, &ea, fa == '0);
    cb = fp_classify(eb == '0, &eb, fb == '0);
    ka = (ca == ZERO) ? '0 : {ea, fa};
    kb = (cb == ZERO) ? '0 : {eb, fb};
    ma = (ca == ZERO) ? '0 : {1'b1, fa};
    mb = (cb == ZERO) ? '0 : {1'b1, fb};
    a_big = (ka >= kb);

    s1_d          = '0;
    s1_d.eff_sub  = sa ^ sb;
    s1_d.sign     = a_big ? sa : sb;
    s1_d.exp_l    = a_big ? ea : eb;
    s1_d.exp_s    = a_big ? eb : ea;
    s1_d.man_l    = a_big ? ma : mb;
    s1_d.man_s    = a_big ? mb : ma;

    if (ca == NAN || cb == NAN) begin
      s1_d.spec     = 1'b1;
      s1_d.spec_val = QNAN;
    end else if (ca == INF && cb == INF && sa != sb) begin
      s1_d.spec     = 1'b1;
      s1_d.spec_val = QNAN;
    end else if (ca == INF) begin
      s1_d.spec     = 1'b1;
      s1_d.spec_val = {sa, INF_MAG[W-2:0]};
    end else if (cb == INF) begin
      s1_d.spec     = 1'b1;
      s1_d.spec_val = {sb, INF_MAG[W-2:0]};
    end
  end

  // S2: align the smaller significand; everything past R folds into sticky.
  logic [EXP_W-1:0] d, sh;
  logic [2*SW-1:0]  wide;

  always_comb begin
    d    = s1_q.exp_l - s1_q.exp_s;
    sh   = (d > SH_MAX) ? SH_MAX : d;
    wide = {s1_q.man_s, 3'b000, {SW{1'b0}}} >> sh;

    s2_d          = '0;
    s2_d.spec     = s1_q.spec;
    s2_d.spec_val = s1_q.spec_val;
    s2_d.sign     = s1_q.sign;
    s2_d.eff_sub  = s1_q.eff_sub;
    s2_d.exp_l    = s1_q.exp_l;
    s2_d.sig_l    = {s1_q.man_l, 3'b000};
    s2_d.sig_s    = {wide[2*SW-1:SW+1], wide[SW] | (|wide[SW-1:0])};
  end

  // S3: add or subtract, then normalise (right by one on carry, else left by lzc).
  logic [SW:0]           sum;
  logic [LZW-1:0]        lz;
  logic signed [EW2-1:0] exp_w;

  ahfp_lzc #(.WIDTH(SW)) u_lzc (
    .vec (sum[SW-1:0]),
    .cnt (lz)
  );

  always_comb begin
    sum   = s2_q.eff_sub ? ({1'b0, s2_q.sig_l} - {1'b0, s2_q.sig_s})
                         : ({1'b0, s2_q.sig_l} + {1'b0, s2_q.sig_s});
    exp_w = {2'b00, s2_q.exp_l};

    s3_d           = '0;
    s3_d.spec      = s2_q.spec;
    s3_d.spec_val  = s2_q.spec_val;
    s3_d.sign      = s2_q.sign;
    s3_d.zero      = (sum == '0);
    // Only two zeros of the same sign can sum to zero without cancelling.
    s3_d.zero_sign = s2_q.eff_sub ? 1'b0 : s2_q.sign;
    if (sum[SW]) begin
      s3_d.norm = {sum[SW:2], sum[1] | sum[0]};
      s3_d.exp  = exp_w + EW2'(1);
    end else begin
      s3_d.norm = sum[SW-1:0] << lz;
      s3_d.exp  = exp_w - EW2'(lz);
    end
  end

  // S4: round to nearest even, then resolve overflow/underflow and specials.
  logic                  round_up;
  logic [MW2-1:0]        mant;
  logic signed [EW2-1:0] exp_r;
  logic [MAN_W-1:0]      frac;

  always_comb begin
    round_up = s3_q.norm[2] & (s3_q.norm[1] | s3_q.norm[0] | s3_q.norm[3]);
    mant     = {1'b0, s3_q.norm[SW-1:3]} + MW2'(round_up);
    exp_r    = s3_q.exp + EW2'(mant[MAN_W+1]);
    frac     = mant[MAN_W+1] ? mant[MAN_W:1] : mant[MAN_W-1:0];

    if (s3_q.spec)
      s4_d = s3_q.spec_val;
    else if (s3_q.zero)
      s4_d = {s3_q.zero_sign, {(W-1){1'b0}}};
    else if (exp_r[EW2-1] || exp_r == '0)
      s4_d = {s3_q.sign, {(W-1){1'b0}}};
    else if (exp_r >= EXP_MAX_S)
      s4_d = {s3_q.sign, INF_MAG[W-2:0]};
    else
      s4_d = {s3_q.sign, exp_r[EXP_W-1:0], frac};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      result   <= '0;
    end else if (clk_en) begin
      vld_pipe <= {vld_pipe[LATENCY-2:0], start};
      if (vld_pipe[LATENCY-2]) result <= s4_d;
    end
  end

  always_ff @(posedge clk) begin
    if (clk_en) begin
      if (start)       s1_q <= s1_d;
      if (vld_pipe[0]) s2_q <= s2_d;
      if (vld_pipe[1]) s3_q <= s3_d;
    end
  end

  assign done = vld_pipe[LATENCY-1];

endmodule

// File: tb/tb_ahfp_addsub_pipe.sv
// Directed bench for ahfp_addsub_pipe: arithmetic, rounding, specials,
// streaming, clk_en stalls and reset flush, against hand-computed results.
module tb_ahfp_addsub_pipe;
  logic        clk, reset, clk_en, start, n;
  logic [31:0] dataa, datab, result;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  logic        sn_tab[6];
  logic [31:0] sa_tab[6], sb_tab[6], se_tab[6];

  ahfp_addsub_pipe dut (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .start  (start),
    .n      (n),
    .dataa  (dataa),
    .datab  (datab),
    .result (result),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issues one op and waits (bounded) for its done pulse; lat = -1 on timeout.
  task automatic run_op(input logic nn, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output logic done_after);
    n = nn; dataa = a; datab = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    res = '0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        res = result;
        break;
      end
    end
    @(posedge clk); #1;
    done_after = done;
  endtask

  task automatic test_reset();
    reset = 1'b1; clk_en = 1'b1; start = 1'b0; n = 1'b0; dataa = '0; datab = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++;
    if (result !== 32'h0) begin n_err++; $display("FAIL reset_result: got %h want 00000000", result); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [31:0] r; int lat; logic da;
    run_op(1'b0, 32'h3F800000, 32'h40000000, r, lat, da);
    n_cmp++;
    if (lat !== 3) begin n_err++; $display("FAIL basic_latency: got %0d want 3", lat); end
    n_cmp++;
    if (r !== 32'h40400000) begin n_err++; $display("FAIL basic_add: got %h want 40400000", r); end
    n_cmp++;
    if (da !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse: got %b want 0", da); end
    run_op(1'b1, 32'h3F800000, 32'h40000000, r, lat, da);
    n_cmp++;
    if (lat !== 3 || r !== 32'hBF800000) begin
      n_err++; $display("FAIL basic_sub: got %h lat %0d want BF800000 lat 3", r, lat);
    end
  endtask

  task automatic test_cancel();
    logic [31:0] r; int lat; logic da;
    run_op(1'b1, 32'h3F800001, 32'h3F800000, r, lat, da);
    n_cmp++;
    if (lat !== 3 || r !== 32'h34000000) begin
      n_err++; $display("FAIL cancel_renorm: got %h lat %0d want 34000000", r, lat);
    end
    run_op(1'b1, 32'h3F800000, 32'h3F800000, r, lat, da);
    n_cmp++;
    if (lat !== 3 || r !== 32'h00000000) begin
      n_err++; $display("FAIL cancel_exact: got %h lat %0d want 00000000", r, lat);
    end
    // min normal minus its successor: 2^-149 underflows to -0
    run_op(1'b1, 32'h00800000, 32'h00800001, r, lat, da);
    n_cmp++;
    if (lat !== 3 || r !== 32'h80000000) begin
      n_err++; $display("FAIL underflow: got %h lat %0d want 80000000", r, lat);
    end
  endtask

  task automatic test_round();
    logic [31:0] r; int lat; logic da;
    logic [31:0] a_v[4]; logic [31:0] b_v[4]; logic [31:0] e_v[4];
    string nm[4];
    a_v = '{32'h3F800000, 32'h3F800000, 32'h3F800001, 32'h3FFFFFFF};
    b_v = '{32'h33800000, 32'h33800001, 32'h33800000, 32'h33800000};
    e_v = '{32'h3F800000, 32'h3F800001, 32'h3F800002, 32'h40000000};
    nm  = '{"round_tie_even_down", "round_above_half", "round_tie_odd_up", "round_carry_exp"};
    for (int i = 0; i < 4; i++) begin
      run_op(1'b0, a_v[i], b_v[i], r, lat, da);
      n_cmp++;
      if (lat !== 3 || r !== e_v[i]) begin
        n_err++; $display("FAIL %s: got %h lat %0d want %h", nm[i], r, lat, e_v[i]);
      end
    end
  endtask

  task automatic test_special();
    logic [31:0] r; int lat; logic da;
    logic        n_v[8];
    logic [31:0] a_v[8]; logic [31:0] b_v[8]; logic [31:0] e_v[8];
    string nm[8];
    n_v = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    a_v = '{32'h7F7FFFFF, 32'h7F800000, 32'h7FA00000, 32'h00000001,
            32'h3F800000, 32'h7F800000, 32'h80000000, 32'h00000000};
    b_v = '{32'h7F7FFFFF, 32'h7F800000, 32'h3F800000, 32'h3F800000,
            32'h7F800000, 32'h3F800000, 32'h80000000, 32'h80000000};
    e_v = '{32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h3F800000,
            32'hFF800000, 32'h7F800000, 32'h80000000, 32'h00000000};
    nm  = '{"overflow", "inf_minus_inf", "nan_in", "denorm_flush",
            "sub_inf", "inf_minus_one", "negzero_sum", "mixed_zero"};
    for (int i = 0; i < 8; i++) begin
      run_op(n_v[i], a_v[i], b_v[i], r, lat, da);
      n_cmp++;
      if (lat !== 3 || r !== e_v[i]) begin
        n_err++; $display("FAIL %s: got %h lat %0d want %h", nm[i], r, lat, e_v[i]);
      end
    end
  endtask

  task automatic load_stream();
    sn_tab = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    sa_tab = '{32'h3F800000, 32'h40000000, 32'h3F800000, 32'h3FC00000, 32'hBF800000, 32'h3F000000};
    sb_tab = '{32'h40000000, 32'h40000000, 32'h3F800000, 32'h3F000000, 32'hBF800000, 32'h3E800000};
    se_tab = '{32'h40400000, 32'h40800000, 32'h00000000, 32'h40000000, 32'hC0000000, 32'h3E800000};
  endtask

  task automatic test_back_to_back();
    int got, first, last;
    load_stream();
    got = 0; first = -1; last = -1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      start = (cyc < 6);
      if (cyc < 6) begin n = sn_tab[cyc]; dataa = sa_tab[cyc]; datab = sb_tab[cyc]; end
      @(posedge clk); #1;
      if (done) begin
        if (got < 6) begin
          n_cmp++;
          if (result !== se_tab[got]) begin
            n_err++; $display("FAIL stream_op%0d: got %h want %h", got, result, se_tab[got]);
          end
        end
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
    end
    start = 1'b0;
    n_cmp++;
    if (got !== 6) begin n_err++; $display("FAIL stream_count: got %0d want 6", got); end
    n_cmp++;
    if (last - first !== 5) begin n_err++; $display("FAIL stream_span: got %0d want 5", last - first); end
  endtask

  task automatic test_stall();
    int got, issued;
    logic stall, pd;
    logic [31:0] pr;
    load_stream();
    got = 0; issued = 0;
    for (int cyc = 0; cyc < 25; cyc++) begin
      stall  = (cyc >= 4 && cyc <= 6);
      clk_en = !stall;
      start  = (issued < 6);
      if (issued < 6) begin n = sn_tab[issued]; dataa = sa_tab[issued]; datab = sb_tab[issued]; end
      pd = done; pr = result;
      @(posedge clk); #1;
      if (stall) begin
        n_cmp++;
        if (done !== pd || result !== pr) begin
          n_err++; $display("FAIL stall_freeze: got %b/%h want %b/%h", done, result, pd, pr);
        end
      end else begin
        if (start) issued++;
        if (done) begin
          if (got < 6) begin
            n_cmp++;
            if (result !== se_tab[got]) begin
              n_err++; $display("FAIL stall_op%0d: got %h want %h", got, result, se_tab[got]);
            end
          end
          got++;
        end
      end
    end
    start = 1'b0; clk_en = 1'b1;
    n_cmp++;
    if (got !== 6) begin n_err++; $display("FAIL stall_count: got %0d want 6", got); end
  endtask

  task automatic test_reset_flush();
    int cnt; logic [31:0] r; int lat; logic da;
    load_stream();
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; n = sn_tab[i]; dataa = sa_tab[i]; datab = sb_tab[i];
      @(posedge clk); #1;
    end
    start = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_cmp++;
    if (done !== 1'b0) begin n_err++; $display("FAIL flush_done: got %b want 0", done); end
    n_cmp++;
    if (result !== 32'h0) begin n_err++; $display("FAIL flush_result: got %h want 00000000", result); end
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
    n_cmp++;
    if (cnt !== 0) begin n_err++; $display("FAIL flush_no_done: got %0d want 0", cnt); end
    run_op(1'b0, 32'h3F800000, 32'h40000000, r, lat, da);
    n_cmp++;
    if (lat !== 3 || r !== 32'h40400000) begin
      n_err++; $display("FAIL post_reset_op: got %h lat %0d want 40400000 lat 3", r, lat);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cancel();
    test_round();
    test_special();
    test_back_to_back();
    test_stall();
    test_reset_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
